// File: rtl/memory_lift_port.sv
// Lift-side block-transfer sequencer for the dual-bank polynomial memory: streams words in (WRITE) or out (READ).
// Optional ZERO fill command is compiled in with `define LIFT_PORT_ZERO_FILL_EN.
module memory_lift_port #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 240
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W:0]   cmd_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              done,
  output logic              busy,
  output logic              lift_interrupt,
  output logic [ADDR_W-1:0] lift_address,
  output logic              lift_we,
  output logic [DATA_W-1:0] lift_wr_data,
  input  logic [DATA_W-1:0] lift_rd_data
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_DONE
`ifdef LIFT_PORT_ZERO_FILL_EN
    , S_ZERO
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic                inflight_q, inflight_d;
  logic [DATA_W-1:0]   fifo_mem_q [2];
  logic                wr_sel_q, rd_sel_q;
  logic [1:0]          fifo_cnt_q;
  logic [1:0]          occ;
  logic                push, pop;

  // Handshakes: a transfer happens on a cycle where valid & ready are both high;
  // valid never depends on ready, and out_data is held while out_valid & !out_ready.
  assign out_valid    = (fifo_cnt_q != 2'd0);
  assign out_data     = fifo_mem_q[rd_sel_q];
  assign pop          = out_valid & out_ready;
  assign push         = inflight_q;
  assign occ          = fifo_cnt_q + {1'b0, inflight_q};
  assign lift_address = ptr_q;

  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    rem_d          = rem_q;
    inflight_d     = 1'b0;
    cmd_ready      = 1'b0;
    busy           = 1'b1;
    in_ready       = 1'b0;
    lift_interrupt = 1'b0;
    lift_we        = 1'b0;
    lift_wr_data   = '0;
    done           = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          ptr_d = cmd_addr;
          rem_d = (cmd_count == '0) ? FULL_CNT : cmd_count;
          case (cmd_op)
            2'd0:    state_d = S_READ;
            2'd1:    state_d = S_WRITE;
`ifdef LIFT_PORT_ZERO_FILL_EN
            2'd2:    state_d = S_ZERO;
`endif
            default: state_d = S_DONE;
          endcase
        end
      end
      S_WRITE: begin
        lift_interrupt = 1'b1;
        in_ready       = 1'b1;
        lift_we        = in_valid;
        lift_wr_data   = in_data;
        if (in_valid) begin
          ptr_d = ptr_q + 1'b1;
          rem_d = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
`ifdef LIFT_PORT_ZERO_FILL_EN
      S_ZERO: begin
        lift_interrupt = 1'b1;
        lift_we        = 1'b1;
        ptr_d          = ptr_q + 1'b1;
        rem_d          = rem_q - 1'b1;
        if (rem_q == CNT_W'(1)) state_d = S_DONE;
      end
`endif
      S_READ: begin
        lift_interrupt = 1'b1;
        // Pop frees a slot this cycle, so a stalled-full pipeline can still sustain 1 word/cycle.
        if (rem_q != '0 && (occ < 2'd2 || pop)) begin
          inflight_d = 1'b1;
          ptr_d      = ptr_q + 1'b1;
          rem_d      = rem_q - 1'b1;
          if (rem_q == CNT_W'(1)) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Memory zeroes read data without ownership, so hold it through the final capture.
        lift_interrupt = inflight_q;
        if (!inflight_q && (fifo_cnt_q == 2'd0 || (fifo_cnt_q == 2'd1 && pop)))
          state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      wr_sel_q      <= 1'b0;
      rd_sel_q      <= 1'b0;
      fifo_cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_sel_q] <= lift_rd_data;
        wr_sel_q             <= ~wr_sel_q;
      end
      if (pop) rd_sel_q <= ~rd_sel_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_lift_port.sv
// Bench for memory_lift_port: behavioural lift memory plus a reference image and an expected-data queue.
module tb_memory_lift_port;

  localparam int AW = 9;
  localparam int DW = 240;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [AW:0]   cmd_count;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic          done, busy, lift_interrupt, lift_we;
  logic [AW-1:0] lift_address;
  logic [DW-1:0] lift_wr_data, lift_rd_data;

  logic [DW-1:0] mem_m [512];
  logic [DW-1:0] rd_q;
  logic [DW-1:0] ref_mem [512];
  logic [DW-1:0] exp_q [$];
  int checks = 0;
  int failures = 0;

  memory_lift_port #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_count(cmd_count),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .done(done), .busy(busy), .lift_interrupt(lift_interrupt),
    .lift_address(lift_address), .lift_we(lift_we),
    .lift_wr_data(lift_wr_data), .lift_rd_data(lift_rd_data)
  );

  // Clock/reset
  always #5 clk = ~clk;

  // Lift memory: synchronous read, data zeroed without ownership.
  always @(posedge clk) begin
    if (lift_interrupt && lift_we) mem_m[lift_address] <= lift_wr_data;
    if (lift_interrupt) rd_q <= mem_m[lift_address];
  end
  assign lift_rd_data = lift_interrupt ? rd_q : '0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk_word(input int idx);
    logic [DW-1:0] w;
    w = '0;
    for (int k = 0; k < 7; k++) w[k*32 +: 32] = $urandom;
    w[DW-1 -: 16] = 16'(idx);
    return w;
  endfunction

  task automatic send_cmd(input logic [1:0] op, input int addr, input int count);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = AW'(addr);
    cmd_count = (AW+1)'(count);
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // op 1 = WRITE from the input stream, op 2 = ZERO fill; gap_mode 1 inserts in_valid holes.
  task automatic run_write(input logic [1:0] op, input int addr, input int count, input int gap_mode);
    int n, written, c, a;
    bit hs, seen_done;
    logic [DW-1:0] w;
    n = (count == 0) ? 512 : count;
    written = 0; a = addr; seen_done = 0;
    send_cmd(op, addr, count);
    c = 1;
    w = mk_word(0);
    while (!seen_done && c < n * 3 + 20) begin
      in_valid = (op == 2'd1) && (gap_mode == 0 || (c % 3) != 2);
      in_data  = w;
      @(negedge clk);
      if (c == 1) begin
        check("wr_busy", busy, 1);
        check("wr_cmd_ready_lo", cmd_ready, 0);
      end
      if (written < n) begin
        hs = (op == 2'd1) ? (in_valid && in_ready) : 1'b1;
        check("wr_irq", lift_interrupt, 1);
        check("wr_we", lift_we, hs);
        check("wr_done_early", done, 0);
        if (op == 2'd2) check("zero_in_ready", in_ready, 0);
        if (hs) begin
          check("wr_addr", lift_address, a);
          check("wr_data", lift_wr_data, (op == 2'd1) ? w : '0);
          ref_mem[a] = (op == 2'd1) ? w : '0;
          a = (a + 1) % 512;
          written++;
          w = mk_word(written);
        end
      end else begin
        check("wr_done", done, 1);
        check("wr_irq_off", lift_interrupt, 0);
        if (gap_mode == 0) check("wr_done_cycle", c, n + 1);
        seen_done = 1;
      end
      @(posedge clk); #1;
      c++;
    end
    in_valid = 1'b0;
    if (!seen_done) check("wr_timeout", 0, 1);
  endtask

  // rdy_mode 0 = out_ready held high, 1 = toggling 1010; rst_at>0 resets when that word pops.
  task automatic run_read(input int addr, input int count, input int rdy_mode, input int rst_at);
    int n, pops, c;
    bit seen_done, stalled, aborted;
    logic [DW-1:0] held, e;
    n = (count == 0) ? 512 : count;
    pops = 0; seen_done = 0; stalled = 0; aborted = 0; held = '0;
    for (int i = 0; i < n; i++) exp_q.push_back(ref_mem[(addr + i) % 512]);
    send_cmd(2'd0, addr, count);
    c = 1;
    while (!seen_done && c < n * 4 + 20) begin
      out_ready = (rdy_mode == 0) ? 1'b1 : ((c % 2) == 1);
      @(negedge clk);
      if (stalled) begin
        check("rd_valid_hold", out_valid, 1);
        check("rd_stable", out_data, held);
      end
      if (pops == n) begin
        check("rd_done", done, 1);
        check("rd_irq_off", lift_interrupt, 0);
        seen_done = 1;
      end else begin
        check("rd_done_early", done, 0);
        check("rd_we", lift_we, 0);
        if (rdy_mode == 0 && c == n + 1) check("rd_irq_drain", lift_interrupt, 1);
        if (rdy_mode == 0 && c == n + 2) check("rd_irq_drop", lift_interrupt, 0);
        if (rdy_mode == 0 && c <= 2) check("rd_latency", out_valid, 0);
        stalled = out_valid && !out_ready;
        held = out_data;
        if (out_valid && out_ready) begin
          if (rdy_mode == 0) check("rd_cycle", c, pops + 3);
          if (exp_q.size() == 0) check("rd_extra", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("rd_data", out_data, e);
          end
          pops++;
          if (rst_at > 0 && pops == rst_at) begin
            rst = 1'b1;
            #1;
            check("rst_irq", lift_interrupt, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_cmd_ready", cmd_ready, 1);
            check("rst_we", lift_we, 0);
            aborted = 1;
            seen_done = 1;
          end
        end
      end
      @(posedge clk); #1;
      c++;
    end
    out_ready = 1'b0;
    if (aborted) begin
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
    end else begin
      if (!seen_done) check("rd_timeout", 0, 1);
      check("rd_queue_empty", exp_q.size(), 0);
    end
  endtask

  task automatic run_noop(input logic [1:0] op);
    send_cmd(op, 7, 5);
    @(negedge clk);
    check("noop_done", done, 1);
    check("noop_we", lift_we, 0);
    check("noop_irq", lift_interrupt, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("noop_idle", cmd_ready, 1);
    check("noop_busy", busy, 0);
  endtask

  initial begin
    int ra, rc;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_count = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_irq", lift_interrupt, 0);
    check("reset_we", lift_we, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 0);
    check("reset_done", done, 0);
    check("reset_addr", lift_address, 0);
    check("reset_wr_data", lift_wr_data, 0);
    check("reset_out_data", out_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_write(2'd1, 0, 0, 0);      // full load
    run_read(0, 0, 0, 0);          // full read-back
    run_read(20, 8, 1, 0);         // backpressure
    run_write(2'd1, 510, 4, 0);    // wrap
    run_read(510, 4, 0, 0);
    run_read(40, 12, 0, 5);        // reset mid-transfer
    run_read(40, 6, 0, 0);
    run_write(2'd1, 300, 3, 1);    // input stall
    run_read(300, 3, 1, 0);
`ifdef LIFT_PORT_ZERO_FILL_EN
    run_write(2'd2, 100, 2, 0);
    run_read(99, 4, 0, 0);
`else
    run_noop(2'd2);
    run_read(99, 4, 0, 0);
`endif
    run_noop(2'd3);
    for (int k = 0; k < 3; k++) begin
      ra = $urandom_range(0, 511);
      rc = $urandom_range(1, 10);
      run_write(2'd1, ra, rc, k % 2);
      run_read(ra, rc, k % 2, 0);
    end
    run_read(505, 10, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/memory_lift_port.md
# memory_lift_port

Sequencer driving the lift side of the dual-bank 2048-coefficient polynomial memory. It accepts block-transfer commands and walks the 240-bit lift address space (512 words) to load a polynomial from an input stream (WRITE) or unload one to an output stream (READ). It owns `lift_interrupt` for the whole transfer, so the compute cores are locked out only while a transfer is active. It sits between the lift unit's streaming datapath and the memory's `lift_*` port.

## Interface
- `ADDR_W`, 9, lift word-address width (512 words).
- `DATA_W`, 240, lift word width (4 × 60-bit coefficients).

Clock and reset: one clock; reset is asynchronous and active-high.

- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-high reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_op` in 2: 0 = READ, 1 = WRITE, 2 = ZERO (only with the macro), 3 = reserved, treated as a no-op.
- `cmd_addr` in ADDR_W: start word address.
- `cmd_count` in ADDR_W+1: word count; 0 means 512.
- `in_valid` in 1: input-stream word valid.
- `in_ready` out 1: input-stream ready.
- `in_data` in DATA_W: input-stream word.
- `out_valid` out 1: output-stream word valid.
- `out_ready` in 1: output-stream ready.
- `out_data` out DATA_W: output-stream word.
- `done` out 1: one-cycle pulse at command completion.
- `busy` out 1: high whenever not in IDLE.
- `lift_interrupt` out 1: memory ownership request.
- `lift_address` out ADDR_W: memory word address.
- `lift_we` out 1: memory write enable.
- `lift_wr_data` out DATA_W: memory write data.
- `lift_rd_data` in DATA_W: memory read data, valid 1 cycle after address.

## Operation
- **States:** IDLE, WRITE, READ, DRAIN, DONE.
- **IDLE:**
  - Command accepted when `cmd_valid & cmd_ready`.
  - Latches the address pointer from `cmd_addr` and the remaining count from `cmd_count`, with 0 mapped to 512.
  - Goes to WRITE or READ per `cmd_op`; op 3 goes straight to DONE.
- **Addressing:** every access uses the pointer, then increments it modulo 512 (511 wraps to 0).
- **WRITE:**
  - `lift_interrupt`=1, `in_ready`=1.
  - `lift_we` = `in_valid`; `lift_wr_data` = `in_data`; one word is written per handshake.
  - After the last handshake, go to DONE.
- **READ, issue side:**
  - `lift_interrupt`=1, `lift_we`=0.
  - A read is issued (pointer advances, remaining count decrements) when words remain and (FIFO occupancy + in-flight) < 2, or a pop happens this cycle.
  - At most one read is in flight.
- **READ, return side:** `lift_rd_data` is pushed into a 2-entry output FIFO the cycle after issue.
- **Output stream:** the FIFO head drives `out_data`/`out_valid`; a pop occurs on `out_valid & out_ready`.
- **READ exit:** after the last issue, go to DRAIN.
- **DRAIN:**
  - `lift_interrupt` stays 1 until the last read's data is captured (one cycle), because the memory zeroes `lift_rd_data` when `lift_interrupt` is low.
  - Then `lift_interrupt` drops.
  - Wait until the FIFO is empty, then go to DONE.
- **DONE:** `done`=1 for one cycle, `lift_interrupt`=0, return to IDLE.
- **Pointer arithmetic:** wrap-around is silent; count 512 starting at any address touches every word exactly once.
- **Reset (including mid-transfer):**
  - Immediately: state IDLE, `lift_interrupt`=0, `lift_we`=0, FIFO flushed.
  - Other outputs: `out_valid`=0, `in_ready`=0, `done`=0, `busy`=0, `cmd_ready`=1, `lift_address`=0, `lift_wr_data`=0, `out_data`=0.

## Timing
- Command accepted in cycle 0; the state is active from cycle 1.
- **WRITE:** the first memory write can occur in cycle 1; throughput is 1 word/cycle; `done` pulses the cycle after the last write.
- **READ:**
  - First address is presented in cycle 1, data is captured at the end of cycle 2, and `out_valid` rises in cycle 3.
  - With `out_ready` held high: 1 word/cycle, and N words occupy cycles 3..N+2.
  - `done` pulses the cycle after the last pop.
- **Backpressure:** `out_ready` low stalls issue once the FIFO plus in-flight reaches 2. No word is lost or duplicated; `out_data` holds stable while `out_valid & !out_ready`.
- `cmd_ready`=0 from cycle 1 until IDLE is re-entered; back-to-back commands have a minimum 1-cycle IDLE gap.

## Configuration
- **`LIFT_PORT_ZERO_FILL_EN` defined:** `cmd_op`=2 is a ZERO command. It behaves like WRITE without the input stream: `lift_we`=1 every cycle, `lift_wr_data`=0, `in_ready`=0, 1 word/cycle, then DONE.
- **Undefined:** op 2 is handled like op 3 (no-op, immediate `done`). No ZERO logic is synthesized.

## Test plan
- **Full load:** WRITE addr 0, count 0, `in_valid` always high, data = index → 512 consecutive `lift_we` cycles, addresses 0..511, `done` in cycle 513. READ back → `out_data` = 0..511 in cycles 3..514.
- **Backpressure:** READ count 8 with `out_ready` toggling 1010… → 8 words in order, no duplicates, `out_data` stable while stalled, never more than 2 buffered.
- **Wrap:** WRITE addr 510, count 4 → `lift_address` sequence 510, 511, 0, 1. READ the same range → matching data.
- **Reset mid-transfer:** assert `rst` during READ word 5 → `lift_interrupt`, `out_valid` and `busy` low in the same cycle. A new READ afterwards returns correct data from its start address.
- **Input stall:** WRITE count 3 with `in_valid` gaps → `lift_we` asserts only on handshake cycles; `lift_interrupt` stays high throughout.
- **Zero-fill:** ZERO addr 100, count 2 with the macro → two `lift_we` cycles with data 0 at addresses 100 and 101. Without the macro → no writes, `done` in cycle 1.
